dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the shared data memory behind the Memory stage. Requester S is the scalar pipeline's LDW/STW port, one word per transaction. Requester V is the GPU vector unit, a fixed-length burst of consecutive words. The block grants the single synchronous SRAM port with round-robin priority, drives the SRAM address/enable/write strobes, returns read data, and raises a stall back to the scalar pipeline while its request waits.

## Interface
- DATA_WIDTH, default 16, word width of the data memory
- ADDR_WIDTH, default 10, word-address width of the data memory
- BURST_LEN, default 4, words per vector burst (minimum 2)

Ports:
- I_CLOCK  in  1  clock; all state updates on negedge, matching the pipeline stages
- I_RESET_N  in  1  reset, asynchronous, active-low
- I_LOCK  in  1  run enable; when 0, no new grants are issued
- I_S_Req / I_S_We  in  1 / 1  scalar request and write select
- I_S_Addr / I_S_WData  in  ADDR_WIDTH / DATA_WIDTH  scalar word address and store data
- O_S_Ack  out  1  one-cycle completion pulse
- O_S_RData  out  DATA_WIDTH  load data, valid with O_S_Ack
- O_S_Stall  out  1  I_S_Req & ~O_S_Ack (combinational)
- I_V_Req / I_V_We  in  1 / 1  burst request and write select (whole burst)
- I_V_Addr  in  ADDR_WIDTH  burst base address
- I_V_WData  in  DATA_WIDTH  current-beat store data
- O_V_Ack  out  1  per-beat completion pulse
- O_V_RData  out  DATA_WIDTH  beat load data, valid with O_V_Ack
- O_V_Done  out  1  pulse with the last beat's O_V_Ack
- O_Mem_En / O_Mem_We  out  1 / 1  SRAM access and write strobe
- O_Mem_Addr / O_Mem_WData  out  ADDR_WIDTH / DATA_WIDTH  SRAM address and write data
- I_Mem_RData  in  DATA_WIDTH  SRAM read data, valid one cycle after the access

## Operation
- States: IDLE, S_ISSUE, S_RESP, V_ISSUE, V_RESP.
- IDLE with I_LOCK=1:
  - only S requesting -> S_ISSUE
  - only V requesting -> V_ISSUE
  - both requesting -> the side not granted last wins; the priority bit resets to "S wins"
  - nothing requesting or I_LOCK=0 -> stay in IDLE
- On any grant, latch the requester's We and address, and set the priority bit to the granted side.
- S_ISSUE: O_Mem_En=1, O_Mem_We=latched We, O_Mem_Addr=latched addr, O_Mem_WData=I_S_WData; -> S_RESP.
- S_RESP: O_S_Ack=1; O_S_RData=I_Mem_RData for reads, 0 for writes; -> IDLE.
- V_ISSUE: drive the SRAM with address = base + beat (modulo 2^ADDR_WIDTH) and O_Mem_WData=I_V_WData; -> V_RESP.
- V_RESP: O_V_Ack=1; O_V_RData as for S. Then:
  - beat==BURST_LEN-1 -> O_V_Done=1, beat cleared, -> IDLE
  - otherwise beat++, -> V_ISSUE
- A burst is never preempted. S waits with O_S_Stall=1.
- I_LOCK falling mid-transaction does not abort it. The transaction completes and the block parks in IDLE.
- Requests must be held until their ack (for V: until O_V_Done). Dropping a request early is a protocol violation with undefined result. A request still high in IDLE after its ack is a new request.
- Outside S_ISSUE and V_ISSUE: O_Mem_En=O_Mem_We=0, O_Mem_Addr=0, O_Mem_WData=0.

## Timing
- Reset, asynchronous: state IDLE, beat=0, priority bit "S wins", latched We and address 0. All outputs 0 except O_S_Stall, which follows I_S_Req.
- Reset mid-transaction aborts immediately with no ack or done. Writes already strobed remain in memory.
- Scalar latency, measured from an IDLE cycle with I_S_Req=1 and S granted: SRAM access next cycle, O_S_Ack the cycle after (3 cycles total).
- Burst occupancy: 1 + 2*BURST_LEN cycles. O_V_Ack pulses every second cycle.
- I_V_WData is sampled in each V_ISSUE cycle. The requester advances its data after each O_V_Ack.
- Back-to-back: IDLE always takes one cycle between transactions; there is no issue from RESP.
- Address wrap: base 0x3FE with BURST_LEN=4 and ADDR_WIDTH=10 accesses 0x3FE, 0x3FF, 0x000, 0x001.

## Test plan
- Scalar store then load: S write 0x1234 to 0x010, then S read of 0x010 -> O_Mem_We=1 only in the first S_ISSUE; the second O_S_Ack carries O_S_RData=0x1234, 3 cycles after its grant.
- Vector read burst: memory preloaded 0x020..0x023 = A,B,C,D; V read at base 0x020 -> four O_V_Ack pulses with A,B,C,D, O_V_Done on the fourth, 9 cycles of occupancy.
- Contention and fairness: S and V both asserted continuously from reset -> grant order S, V, S, V. O_S_Stall stays high throughout each vector burst.
- Wrap-around: V write burst at 0x3FE with data 1,2,3,4 -> memory 0x3FE=1, 0x3FF=2, 0x000=3, 0x001=4.
- Lock gating: I_LOCK=0 with I_S_Req=1 -> no O_Mem_En and O_S_Stall=1. I_LOCK falls during V beat 2 -> the burst completes with O_V_Done, then no further grants.
- Async reset mid-burst: I_RESET_N low between negedges during V beat 1 -> all outputs 0 immediately, no O_V_Done. After release, the next S request completes normally with S priority.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the shared data SRAM: scalar single-word
// transactions (S) and fixed-length vector bursts (V) share one synchronous port.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BURST_LEN  = 4
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET_N,
    input  logic                  I_LOCK,
    input  logic                  I_S_Req,
    input  logic                  I_S_We,
    input  logic [ADDR_WIDTH-1:0] I_S_Addr,
    input  logic [DATA_WIDTH-1:0] I_S_WData,
    output logic                  O_S_Ack,
    output logic [DATA_WIDTH-1:0] O_S_RData,
    output logic                  O_S_Stall,
    input  logic                  I_V_Req,
    input  logic                  I_V_We,
    input  logic [ADDR_WIDTH-1:0] I_V_Addr,
    input  logic [DATA_WIDTH-1:0] I_V_WData,
    output logic                  O_V_Ack,
    output logic [DATA_WIDTH-1:0] O_V_RData,
    output logic                  O_V_Done,
    output logic                  O_Mem_En,
    output logic                  O_Mem_We,
    output logic [ADDR_WIDTH-1:0] O_Mem_Addr,
    output logic [DATA_WIDTH-1:0] O_Mem_WData,
    input  logic [DATA_WIDTH-1:0] I_Mem_RData
);
    localparam int BW = $clog2(BURST_LEN);

    typedef enum logic [2:0] {IDLE, S_ISSUE, S_RESP, V_ISSUE, V_RESP} state_t;

    state_t                state, state_nxt;
    logic [BW-1:0]         beat;
    logic                  last_v;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  last_beat;

    assign last_beat = (beat == BW'(BURST_LEN - 1));

    // last_v records the side granted most recently; it resets to V so S wins first.
    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state    <= IDLE;
            beat     <= '0;
            last_v   <= 1'b1;
            lat_we   <= 1'b0;
            lat_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == S_ISSUE) begin
                lat_we   <= I_S_We;
                lat_addr <= I_S_Addr;
                last_v   <= 1'b0;
            end else if (state == IDLE && state_nxt == V_ISSUE) begin
                lat_we   <= I_V_We;
                lat_addr <= I_V_Addr;
                last_v   <= 1'b1;
            end
            if (state == V_RESP)
                beat <= last_beat ? '0 : beat + BW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (I_LOCK) begin
                    if (I_S_Req && I_V_Req)
                        state_nxt = last_v ? S_ISSUE : V_ISSUE;
                    else if (I_S_Req)
                        state_nxt = S_ISSUE;
                    else if (I_V_Req)
                        state_nxt = V_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_RESP;
            S_RESP:  state_nxt = IDLE;
            V_ISSUE: state_nxt = V_RESP;
            V_RESP:  state_nxt = last_beat ? IDLE : V_ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        O_Mem_En    = 1'b0;
        O_Mem_We    = 1'b0;
        O_Mem_Addr  = '0;
        O_Mem_WData = '0;
        O_S_Ack     = 1'b0;
        O_S_RData   = '0;
        O_V_Ack     = 1'b0;
        O_V_RData   = '0;
        O_V_Done    = 1'b0;
        case (state)
            S_ISSUE: begin
                O_Mem_En    = 1'b1;
                O_Mem_We    = lat_we;
                O_Mem_Addr  = lat_addr;
                O_Mem_WData = I_S_WData;
            end
            S_RESP: begin
                O_S_Ack   = 1'b1;
                O_S_RData = lat_we ? '0 : I_Mem_RData;
            end
            V_ISSUE: begin
                // Beat offset wraps naturally at the address width.
                O_Mem_En    = 1'b1;
                O_Mem_We    = lat_we;
                O_Mem_Addr  = lat_addr + ADDR_WIDTH'(beat);
                O_Mem_WData = I_V_WData;
            end
            V_RESP: begin
                O_V_Ack   = 1'b1;
                O_V_RData = lat_we ? '0 : I_Mem_RData;
                O_V_Done  = last_beat;
            end
            default: ;
        endcase
    end

    assign O_S_Stall = I_S_Req & ~O_S_Ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a behavioural SRAM model.
module tb_dmem_arbiter;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int BL = 4;

    logic          clk, rst_n, lock;
    logic          s_req, s_we, s_ack, s_stall;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          v_req, v_we, v_ack, v_done;
    logic [AW-1:0] v_addr;
    logic [DW-1:0] v_wdata, v_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;
    int pat [4] = '{'hAAAA, 'hBBBB, 'hCCCC, 'hDDDD};

    typedef struct {
        logic          s_req, s_we;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wd;
        logic          v_req, v_we;
        logic [AW-1:0] v_addr;
        logic [DW-1:0] v_wd;
        logic          lock;
        logic          en, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          sack;
        logic [DW-1:0] srd;
        logic          vack;
        logic [DW-1:0] vrd;
        logic          done, stall;
    } row_t;

    row_t tbl [$];

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
        .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(lock),
        .I_S_Req(s_req), .I_S_We(s_we), .I_S_Addr(s_addr), .I_S_WData(s_wdata),
        .O_S_Ack(s_ack), .O_S_RData(s_rdata), .O_S_Stall(s_stall),
        .I_V_Req(v_req), .I_V_We(v_we), .I_V_Addr(v_addr), .I_V_WData(v_wdata),
        .O_V_Ack(v_ack), .O_V_RData(v_rdata), .O_V_Done(v_done),
        .O_Mem_En(mem_en), .O_Mem_We(mem_we), .O_Mem_Addr(mem_addr),
        .O_Mem_WData(mem_wdata), .I_Mem_RData(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: sampled on the same edge the arbiter advances on.
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    function automatic row_t mk(input int sr, sw, sa, sd, vr, vw, va, vd, lk,
                                input int en, we, a, wd, sk, srd, vk, vrd, dn, st);
        row_t r;
        r.s_req = sr[0];  r.s_we = sw[0];  r.s_addr = AW'(sa);  r.s_wd = DW'(sd);
        r.v_req = vr[0];  r.v_we = vw[0];  r.v_addr = AW'(va);  r.v_wd = DW'(vd);
        r.lock  = lk[0];
        r.en    = en[0];  r.we   = we[0];  r.addr   = AW'(a);   r.wd   = DW'(wd);
        r.sack  = sk[0];  r.srd  = DW'(srd);
        r.vack  = vk[0];  r.vrd  = DW'(vrd);
        r.done  = dn[0];  r.stall = st[0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input row_t r);
        s_req = r.s_req;  s_we = r.s_we;  s_addr = r.s_addr;  s_wdata = r.s_wd;
        v_req = r.v_req;  v_we = r.v_we;  v_addr = r.v_addr;  v_wdata = r.v_wd;
        lock  = r.lock;
    endtask

    task automatic chk_out(input string t, input row_t e);
        chk({t, ".en"},    32'(mem_en),    32'(e.en));
        chk({t, ".we"},    32'(mem_we),    32'(e.we));
        chk({t, ".addr"},  32'(mem_addr),  32'(e.addr));
        chk({t, ".wdata"}, 32'(mem_wdata), 32'(e.wd));
        chk({t, ".sack"},  32'(s_ack),     32'(e.sack));
        chk({t, ".srd"},   32'(s_rdata),   32'(e.srd));
        chk({t, ".vack"},  32'(v_ack),     32'(e.vack));
        chk({t, ".vrd"},   32'(v_rdata),   32'(e.vrd));
        chk({t, ".done"},  32'(v_done),    32'(e.done));
        chk({t, ".stall"}, 32'(s_stall),   32'(e.stall));
    endtask

    // Inputs change just after posedge; outputs are checked before the next negedge.
    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(posedge clk);
            #1 drive(tbl[i]);
            #1 chk_out($sformatf("row%0d", i), tbl[i]);
        end
    endtask

    // One full burst; sr also holds a scalar read of 0x010 pending, lock drops from beat 2 if lk2=0.
    task automatic add_burst(input int sr, input int we, input int base, input int lk2);
        for (int b = 0; b < BL; b++) begin
            int lk = (b >= 2) ? lk2 : 1;
            int wd = (we != 0) ? b + 1 : 0;
            int rd = (we != 0) ? 0 : pat[b];
            int a  = (base + b) % (1 << AW);
            tbl.push_back(mk(sr,0,'h010,0, 1,we,base,wd, lk, 1,we,a,wd, 0,0, 0,0, 0,sr));
            tbl.push_back(mk(sr,0,'h010,0, 1,we,base,wd, lk, 0,0,0,0, 0,0, 1,rd, int'(b == BL-1),sr));
        end
    endtask

    task automatic add_idle(input int sr, input int vr, input int lk);
        tbl.push_back(mk(sr,0,'h010,0, vr,0,'h020,0, lk, 0,0,0,0, 0,0, 0,0, 0,sr));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   n_a;
        row_t r;

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem['h020 + i] = DW'(pat[i]);

        rst_n = 1'b0;
        drive(mk(1,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0, 0,0, 0,0));
        #2 chk_out("reset", mk(1,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0, 0,0, 0,1));
        s_req = 1'b0;
        #1 chk("reset.stall_follows", 32'(s_stall), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // scalar store 0x1234 -> 0x010, then load it back
        tbl.push_back(mk(1,1,'h010,'h1234, 0,0,0,0, 1, 0,0,0,0,           0,0,       0,0, 0,1));
        tbl.push_back(mk(1,1,'h010,'h1234, 0,0,0,0, 1, 1,1,'h010,'h1234,  0,0,       0,0, 0,1));
        tbl.push_back(mk(1,1,'h010,'h1234, 0,0,0,0, 1, 0,0,0,0,           1,0,       0,0, 0,0));
        tbl.push_back(mk(1,0,'h010,0,      0,0,0,0, 1, 0,0,0,0,           0,0,       0,0, 0,1));
        tbl.push_back(mk(1,0,'h010,0,      0,0,0,0, 1, 1,0,'h010,0,       0,0,       0,0, 0,1));
        tbl.push_back(mk(1,0,'h010,0,      0,0,0,0, 1, 0,0,0,0,           1,'h1234,  0,0, 0,0));
        add_idle(0, 0, 1);
        // vector read burst at 0x020
        tbl.push_back(mk(0,0,0,0, 1,0,'h020,0, 1, 0,0,0,0, 0,0, 0,0, 0,0));
        add_burst(0, 0, 'h020, 1);
        add_idle(0, 0, 1);
        // vector write burst wrapping past the top of memory
        tbl.push_back(mk(0,0,0,0, 1,1,'h3FE,1, 1, 0,0,0,0, 0,0, 0,0, 0,0));
        add_burst(0, 1, 'h3FE, 1);
        add_idle(0, 0, 1);
        // scalar read of 0x3FE leaves S as the last grant before the next reset
        tbl.push_back(mk(1,0,'h3FE,0, 0,0,0,0, 1, 0,0,0,0,      0,0, 0,0, 0,1));
        tbl.push_back(mk(1,0,'h3FE,0, 0,0,0,0, 1, 1,0,'h3FE,0, 0,0, 0,0, 0,1));
        tbl.push_back(mk(1,0,'h3FE,0, 0,0,0,0, 1, 0,0,0,0,      1,1, 0,0, 0,0));
        add_idle(0, 0, 1);
        n_a = tbl.size();

        // contention from reset: S, V, S, V
        for (int rep = 0; rep < 2; rep++) begin
            add_idle(1, 1, 1);
            tbl.push_back(mk(1,0,'h010,0, 1,0,'h020,0, 1, 1,0,'h010,0, 0,0,       0,0, 0,1));
            tbl.push_back(mk(1,0,'h010,0, 1,0,'h020,0, 1, 0,0,0,0,      1,'h1234, 0,0, 0,0));
            add_idle(1, 1, 1);
            add_burst(1, 0, 'h020, 1);
        end
        add_idle(0, 0, 1);
        // lock gating: no grant while locked; lock drops mid-burst
        for (int i = 0; i < 3; i++) add_idle(1, 0, 0);
        add_idle(0, 1, 1);
        add_burst(0, 0, 'h020, 0);
        for (int i = 0; i < 3; i++) add_idle(1, 1, 0);
        add_idle(0, 0, 0);

        run(0, n_a);

        chk("mem3FE", 32'(mem['h3FE]), 32'd1);
        chk("mem3FF", 32'(mem['h3FF]), 32'd2);
        chk("mem000", 32'(mem['h000]), 32'd3);
        chk("mem001", 32'(mem['h001]), 32'd4);
        chk("mem010", 32'(mem['h010]), 32'h1234);

        @(posedge clk);
        #1 rst_n = 1'b0;
        drive(mk(0,0,0,0, 0,0,0,0, 1, 0,0,0,0, 0,0, 0,0, 0,0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(n_a, tbl.size());

        // asynchronous reset during V beat 1
        r = mk(0,0,0,0, 1,0,'h020,0, 1, 0,0,0,0, 0,0, 0,0, 0,0);
        @(posedge clk); #1 drive(r); #1 chk_out("rb.idle", r);
        @(posedge clk); #2 chk_out("rb.iss0", mk(0,0,0,0, 1,0,'h020,0, 1, 1,0,'h020,0, 0,0, 0,0,      0,0));
        @(posedge clk); #2 chk_out("rb.rsp0", mk(0,0,0,0, 1,0,'h020,0, 1, 0,0,0,0,      0,0, 1,'hAAAA, 0,0));
        @(posedge clk); #2 chk_out("rb.iss1", mk(0,0,0,0, 1,0,'h020,0, 1, 1,0,'h021,0, 0,0, 0,0,      0,0));
        #1 rst_n = 1'b0;
        s_req = 1'b1;
        #1 chk_out("rb.rst", mk(1,0,0,0, 1,0,'h020,0, 1, 0,0,0,0, 0,0, 0,0, 0,1));
        @(posedge clk); #2 chk_out("rb.hold", mk(1,0,0,0, 1,0,'h020,0, 1, 0,0,0,0, 0,0, 0,0, 0,1));
        #1 rst_n = 1'b1;
        r = mk(1,0,'h010,0, 1,0,'h020,0, 1, 0,0,0,0, 0,0, 0,0, 0,1);
        drive(r);
        #1 chk_out("rb.rel", r);
        @(posedge clk); #2 chk_out("rb.siss", mk(1,0,'h010,0, 1,0,'h020,0, 1, 1,0,'h010,0, 0,0,       0,0, 0,1));
        @(posedge clk); #2 chk_out("rb.srsp", mk(1,0,'h010,0, 1,0,'h020,0, 1, 0,0,0,0,      1,'h1234, 0,0, 0,0));
        r = mk(0,0,0,0, 0,0,0,0, 1, 0,0,0,0, 0,0, 0,0, 0,0);
        @(posedge clk); #1 drive(r); #1 chk_out("rb.end", r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
